// File: rtl/alu_out_stage.sv
// alu_out_stage: two-entry in-order output buffer between the ALU and the
// writeback consumer. Entries carry the ALU result and its operation tag.
// Optional build macro ALU_OUT_FLAGS_EN: when defined, zero/negative flags
// are computed as each entry is captured and stored alongside it. When it is
// undefined, no flag storage exists and out_zero/out_neg are tied to 0.
// Handshake status (in_ready/out_valid) is decoded from the registered
// occupancy count only, so there is no path from in_valid or out_ready.

module alu_out_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_op,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    input  logic             out_ready
);

    logic [1:0]       count;
    logic [WIDTH-1:0] head_result;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] tail_result;
    logic [2:0]       tail_op;

    logic push;
    logic pop;
    logic load_head_new;
    logic load_tail_new;
    logic load_head_tail;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head takes the incoming entry when the buffer is empty, or when the
    // single held entry leaves in the same cycle; otherwise a push lands in
    // the tail slot. A pop from a full buffer promotes the tail.
    assign load_head_new  = push & ((count == 2'd0) | (pop & (count == 2'd1)));
    assign load_tail_new  = push & ~pop & (count == 2'd1);
    assign load_head_tail = pop & (count == 2'd2);

    // Occupancy counter and data slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= 2'd0;
            head_result <= '0;
            head_op     <= '0;
            tail_result <= '0;
            tail_op     <= '0;
        end else begin
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
            if (load_head_new) begin
                head_result <= in_result;
                head_op     <= in_op;
            end else if (load_head_tail) begin
                head_result <= tail_result;
                head_op     <= tail_op;
            end
            if (load_tail_new) begin
                tail_result <= in_result;
                tail_op     <= in_op;
            end
        end
    end

    assign out_result = head_result;
    assign out_op     = head_op;

`ifdef ALU_OUT_FLAGS_EN
    logic head_zero;
    logic head_neg;
    logic tail_zero;
    logic tail_neg;
    logic in_zero;
    logic in_neg;

    assign in_zero = (in_result == '0);
    assign in_neg  = in_result[WIDTH-1];

    // Flags follow their entry through the same slot moves as the data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_zero <= 1'b0;
            head_neg  <= 1'b0;
            tail_zero <= 1'b0;
            tail_neg  <= 1'b0;
        end else begin
            if (load_head_new) begin
                head_zero <= in_zero;
                head_neg  <= in_neg;
            end else if (load_head_tail) begin
                head_zero <= tail_zero;
                head_neg  <= tail_neg;
            end
            if (load_tail_new) begin
                tail_zero <= in_zero;
                tail_neg  <= in_neg;
            end
        end
    end

    assign out_zero = head_zero;
    assign out_neg  = head_neg;
`else
    assign out_zero = 1'b0;
    assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_out_stage.sv
// Testbench for alu_out_stage: directed scenarios plus randomized
// back-pressure, checked against a queue-based reference model.

module tb_alu_out_stage;

    localparam int WIDTH = 32;
`ifdef ALU_OUT_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_op;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_ready;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [2:0]       op;
    } entry_t;

    entry_t model_q[$];
    int total = 0;
    int bad   = 0;

    alu_out_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_result (in_result),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_result(out_result),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic exp_zero(input logic [WIDTH-1:0] v);
        return FLAGS && (v == 0);
    endfunction

    function automatic logic exp_neg(input logic [WIDTH-1:0] v);
        return FLAGS && v[WIDTH-1];
    endfunction

    // One clock: the model applies the handshake seen at the rising edge,
    // then control returns at the falling edge for checking and driving.
    task automatic tick();
        bit do_push;
        bit do_pop;
        entry_t e;
        @(posedge clk);
        do_push = in_valid && (model_q.size() < 2);
        do_pop  = out_ready && (model_q.size() > 0);
        e.res = in_result;
        e.op  = in_op;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_op     = '0;
        out_ready = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_result !== '0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        total++; if (out_op !== 3'd0) begin bad++; $display("FAIL reset_out_op got=%0d want=0", out_op); end
        total++; if (out_zero !== 1'b0 || out_neg !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", out_zero, out_neg); end
        @(negedge clk);
        reset_n = 1'b1;
        model_q.delete();
    endtask

    task automatic test_single_pass();
        in_valid  = 1'b1;
        in_result = 32'hFFFF_FFFE;
        in_op     = 3'd3;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
        total++; if (out_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL single_result got=%h want=fffffffe", out_result); end
        total++; if (out_op !== 3'd3) begin bad++; $display("FAIL single_op got=%0d want=3", out_op); end
        total++; if (out_neg !== FLAGS) begin bad++; $display("FAIL single_neg got=%b want=%b", out_neg, FLAGS); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL single_zero got=%b want=0", out_zero); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h0;
        in_op     = 3'd1;
        tick();
        in_result = 32'h1234_5678;
        in_op     = 3'd2;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
        total++; if (out_zero !== FLAGS) begin bad++; $display("FAIL fill_zero got=%b want=%b", out_zero, FLAGS); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL fill_head got=%h want=0", out_result); end
        in_result = 32'hDEAD_BEEF;
        in_op     = 3'd7;
        tick();
        in_valid = 1'b0;
        total++; if (out_result !== 32'h0 || out_op !== 3'd1) begin bad++; $display("FAIL fill_drop_head got=%h/%0d want=0/1", out_result, out_op); end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_result !== 32'h1234_5678 || out_op !== 3'd2) begin bad++; $display("FAIL fill_second got=%b/%h/%0d want=1/12345678/2", out_valid, out_result, out_op); end
        total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL fill_second_zero got=%b want=0", out_zero); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_drop_leak got=%b want=0", out_valid); end
    endtask

    task automatic test_concurrent();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'hA;
        in_op     = 3'd4;
        tick();
        total++; if (out_result !== 32'hA) begin bad++; $display("FAIL conc_head got=%h want=a", out_result); end
        in_result = 32'hB;
        in_op     = 3'd5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'hB || out_op !== 3'd5) begin bad++; $display("FAIL conc_new_head got=%b/%h/%0d want=1/b/5", out_valid, out_result, out_op); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL conc_count got in_ready=%b want=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL conc_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h1111_1111;
        in_op     = 3'd1;
        tick();
        in_result = 32'h2222_2222;
        in_op     = 3'd2;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_full got=%b/%b want=1/0", out_valid, in_ready); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_async got=%b/%b want=0/1", out_valid, in_ready); end
        total++; if (out_result !== '0 || out_op !== 3'd0) begin bad++; $display("FAIL rstmid_data got=%h/%0d want=0/0", out_result, out_op); end
        #1 reset_n = 1'b1;
        model_q.delete();
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale cyc=%0d got=%b want=0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        int pushes = 0;
        int cycles = 0;
        bit hold = 0;
        logic [WIDTH-1:0] prev_res;
        logic [2:0] prev_op;
        logic prev_z, prev_n;
        while (pushes < 1000 && cycles < 20000) begin
            total++; if (out_valid !== (model_q.size() != 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cycles, out_valid, model_q.size() != 0); end
            total++; if (in_ready !== (model_q.size() < 2)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cycles, in_ready, model_q.size() < 2); end
            if (model_q.size() != 0) begin
                total++; if (out_result !== model_q[0].res || out_op !== model_q[0].op) begin bad++; $display("FAIL rnd_head cyc=%0d got=%h/%0d want=%h/%0d", cycles, out_result, out_op, model_q[0].res, model_q[0].op); end
                total++; if (out_zero !== exp_zero(model_q[0].res) || out_neg !== exp_neg(model_q[0].res)) begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b%b want=%b%b", cycles, out_zero, out_neg, exp_zero(model_q[0].res), exp_neg(model_q[0].res)); end
            end
            if (hold) begin
                total++; if (out_result !== prev_res || out_op !== prev_op || out_zero !== prev_z || out_neg !== prev_n) begin bad++; $display("FAIL rnd_stable cyc=%0d got=%h/%0d want=%h/%0d", cycles, out_result, out_op, prev_res, prev_op); end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            in_result = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            in_op     = 3'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            hold      = out_valid && !out_ready;
            prev_res  = out_result;
            prev_op   = out_op;
            prev_z    = out_zero;
            prev_n    = out_neg;
            if (in_valid && model_q.size() < 2) pushes++;
            tick();
            cycles++;
        end
        total++; if (pushes < 1000) begin bad++; $display("FAIL rnd_budget got=%0d pushes want=1000", pushes); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (model_q.size() != 0) begin
                total++; if (out_result !== model_q[0].res) begin bad++; $display("FAIL rnd_drain got=%h want=%h", out_result, model_q[0].res); end
            end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_empty got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill_stall();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
